// File: rtl/mux_tree_pipe_pkg.sv
// Shared definitions for the pipelined N:1 multiplexer tree: sizing helpers,
// channel slicing and scan-mode encoding.
package mux_tree_pipe_pkg;

    // Scan-mode encoding of the scan_en input
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2 for sizing select and counter fields (returns 0 for value <= 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // LSB position of channel ch inside a packed array of w-bit channels
    function automatic int ch_lsb(input int ch, input int w);
        return ch * w;
    endfunction

    // Bit offset of tree level k inside the flattened tree vector.
    // Level 0 is the raw input (n channels), level k holds n>>k channels,
    // so the levels before k occupy w*(2n - 2*(n>>k)) bits.
    function automatic int lvl_off(input int n, input int w, input int k);
        return w * (2 * n - 2 * (n >> k));
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Channel bus of the mux tree: packed channel inputs, select/mode controls,
// the selected output with its tag, and scan observability.
interface mux_tree_pipe_if #(
    parameter int W = 1,
    parameter int N = 16
);
    import mux_tree_pipe_pkg::*;

    localparam int L = clog2(N);

    logic [N*W-1:0] din;
    logic [L-1:0]   sel;
    logic           scan_en;
    logic           in_valid;
    logic [W-1:0]   dout;
    logic [L-1:0]   dout_sel;
    logic           out_valid;
    logic [L-1:0]   scan_ptr;
    logic           scan_wrap;

    // Source side: drives channels and controls, observes the result
    modport master (
        output din, sel, scan_en, in_valid,
        input  dout, dout_sel, out_valid, scan_ptr, scan_wrap
    );

    // Mux tree side
    modport slave (
        input  din, sel, scan_en, in_valid,
        output dout, dout_sel, out_valid, scan_ptr, scan_wrap
    );

endinterface

// File: rtl/mux_tree_pipe_mux_level.sv
// One registered level of the mux tree: M channels in, M/2 channels out.
// The full select travels with the data so every level, and the output tag,
// refer to the select of the snapshot being carried.
module mux_level
    import mux_tree_pipe_pkg::*;
#(
    parameter int M = 2,
    parameter int W = 1,
    parameter int L = 1,
    parameter int K = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [M*W-1:0]     d_in,
    input  logic [L-1:0]       sel_in,
    input  logic               v_in,
    output logic [(M/2)*W-1:0] d_out,
    output logic [L-1:0]       sel_out,
    output logic               v_out
);

    logic [(M/2)*W-1:0] pick_s;

    // Pairwise 2:1 selection on select bit K (channels 2j and 2j+1 -> j)
    always_comb begin
        pick_s = '0;
        for (int j = 0; j < M / 2; j++) begin
            pick_s[ch_lsb(j, W) +: W] = sel_in[K] ? d_in[ch_lsb(2 * j + 1, W) +: W]
                                                  : d_in[ch_lsb(2 * j, W) +: W];
        end
    end

    // Level register: data, select tag and valid advance every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out   <= '0;
            sel_out <= '0;
            v_out   <= 1'b0;
        end else begin
            d_out   <= pick_s;
            sel_out <= sel_in;
            v_out   <= v_in;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree for W-bit channels. One register stage per
// tree level gives a fixed latency of log2(N) cycles; the channel index and a
// valid flag ride alongside the data. The select is either external or comes
// from a scan pointer that dwells DWELL cycles per channel and wraps.
module mux_tree_pipe
    import mux_tree_pipe_pkg::*;
#(
    parameter int W     = 1,
    parameter int N     = 16,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_tree_pipe_if.slave bus
);

    localparam int L         = clog2(N);
    localparam int CH_W      = W;
    localparam int DW        = (DWELL > 1) ? clog2(DWELL) : 1;
    localparam int TREE_BITS = (2 * N - 1) * CH_W;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [L-1:0]  PTR_LAST   = L'(N - 1);
    localparam logic [L-1:0]  PTR_ONE    = L'(1);

    logic [L-1:0]     scan_ptr_r;
    logic [DW-1:0]    dwell_r;
    logic             scan_wrap_r;
    logic [L-1:0]     esel_s;

    // Flattened tree: level 0 is din, level L is the single selected channel
    logic [TREE_BITS-1:0] tree_d_s;
    logic [L-1:0]         tree_sel_s [0:L];
    logic [L:0]           tree_v_s;

    // Effective select: scan pointer in scan mode, external select otherwise
    always_comb begin
        esel_s = bus.sel;
        if (bus.scan_en == MODE_SCAN) begin
            esel_s = scan_ptr_r;
        end else begin
            esel_s = bus.sel;
        end
    end

    // Scan pointer with dwell counter; wrap pulse registered with the N-1 -> 0 step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ptr_r  <= '0;
            dwell_r     <= '0;
            scan_wrap_r <= 1'b0;
        end else if (bus.scan_en == MODE_SCAN) begin
            if (dwell_r == DWELL_LAST) begin
                dwell_r     <= '0;
                scan_ptr_r  <= scan_ptr_r + PTR_ONE;
                scan_wrap_r <= (scan_ptr_r == PTR_LAST);
            end else begin
                dwell_r     <= dwell_r + DWELL_ONE;
                scan_wrap_r <= 1'b0;
            end
        end else begin
            scan_wrap_r <= 1'b0;
        end
    end

    assign tree_d_s[N*CH_W-1:0] = bus.din;
    assign tree_sel_s[0]        = esel_s;
    assign tree_v_s[0]          = bus.in_valid;

    for (genvar k = 0; k < L; k++) begin : g_level
        localparam int M_IN    = N >> k;
        localparam int OFF_IN  = lvl_off(N, CH_W, k);
        localparam int OFF_OUT = lvl_off(N, CH_W, k + 1);

        mux_level #(
            .M (M_IN),
            .W (CH_W),
            .L (L),
            .K (k)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .d_in    (tree_d_s[OFF_IN +: M_IN*CH_W]),
            .sel_in  (tree_sel_s[k]),
            .v_in    (tree_v_s[k]),
            .d_out   (tree_d_s[OFF_OUT +: (M_IN/2)*CH_W]),
            .sel_out (tree_sel_s[k+1]),
            .v_out   (tree_v_s[k+1])
        );
    end

    // All outputs come straight from registers
    assign bus.dout      = tree_d_s[TREE_BITS-1 -: CH_W];
    assign bus.dout_sel  = tree_sel_s[L];
    assign bus.out_valid = tree_v_s[L];
    assign bus.scan_ptr  = scan_ptr_r;
    assign bus.scan_wrap = scan_wrap_r;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: a 16x8-bit instance (DWELL=4) driven
// through directed and random phases, and a 2x1-bit instance (DWELL=1) driven
// randomly throughout. Expected outputs come from a channel-indexing model
// with a scan position counted in enabled cycles.
module tb_mux_tree_pipe;

    localparam int N_A = 16, W_A = 8, DWELL_A = 4, L_A = 4;
    localparam int N_B = 2,  W_B = 1, DWELL_B = 1, L_B = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    mux_tree_pipe_if #(.W(W_A), .N(N_A)) bus_a ();
    mux_tree_pipe_if #(.W(W_B), .N(N_B)) bus_b ();

    mux_tree_pipe #(.W(W_A), .N(N_A), .DWELL(DWELL_A)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a.slave)
    );
    mux_tree_pipe #(.W(W_B), .N(N_B), .DWELL(DWELL_B)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic [3:0] s; int due; } ent_a_t;
    typedef struct { logic d; logic s; int due; } ent_b_t;

    ent_a_t qa[$];
    ent_b_t qb[$];
    int ea = 0, eb = 0;              // edge counters seen by each model
    int sa = 0, sb = 0;              // scan-enabled cycles since reset
    int exp_ptr_a = 0, exp_ptr_b = 0;
    logic exp_wrap_a = 1'b0, exp_wrap_b = 1'b0;
    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model A: picks the channel named by the effective select
    initial forever begin
        int es;
        @(posedge clk);
        if (rst_n) begin
            ea++;
            es = bus_a.scan_en ? (sa / DWELL_A) % N_A : int'(bus_a.sel);
            if (bus_a.in_valid)
                qa.push_back('{d: bus_a.din[es*8 +: 8], s: 4'(es), due: ea + L_A - 1});
            if (bus_a.scan_en) begin
                sa++;
                exp_wrap_a = ((sa % (N_A * DWELL_A)) == 0);
            end else begin
                exp_wrap_a = 1'b0;
            end
            exp_ptr_a = (sa / DWELL_A) % N_A;
        end
    end

    // Reference model B
    initial forever begin
        int es;
        @(posedge clk);
        if (rst_n) begin
            eb++;
            es = bus_b.scan_en ? (sb / DWELL_B) % N_B : int'(bus_b.sel);
            if (bus_b.in_valid)
                qb.push_back('{d: bus_b.din[es], s: 1'(es), due: eb + L_B - 1});
            if (bus_b.scan_en) begin
                sb++;
                exp_wrap_b = ((sb % (N_B * DWELL_B)) == 0);
            end else begin
                exp_wrap_b = 1'b0;
            end
            exp_ptr_b = (sb / DWELL_B) % N_B;
        end
    end

    // Monitor A: compares every cycle on the falling edge
    initial forever begin
        logic exp_v;
        ent_a_t e;
        @(negedge clk);
        if (!rst_n) begin
            check("a_rst_out_valid", bus_a.out_valid, 0);
            check("a_rst_scan_ptr", bus_a.scan_ptr, 0);
        end else begin
            check("a_scan_ptr", bus_a.scan_ptr, exp_ptr_a);
            check("a_scan_wrap", bus_a.scan_wrap, exp_wrap_a);
            exp_v = (qa.size() > 0) && (qa[0].due == ea);
            check("a_out_valid", bus_a.out_valid, exp_v);
            if (exp_v) begin
                e = qa.pop_front();
                if (bus_a.out_valid) begin
                    check("a_dout", bus_a.dout, e.d);
                    check("a_dout_sel", bus_a.dout_sel, e.s);
                end
            end
        end
    end

    // Monitor B
    initial forever begin
        logic exp_v;
        ent_b_t e;
        @(negedge clk);
        if (!rst_n) begin
            check("b_rst_out_valid", bus_b.out_valid, 0);
        end else begin
            check("b_scan_ptr", bus_b.scan_ptr, exp_ptr_b);
            check("b_scan_wrap", bus_b.scan_wrap, exp_wrap_b);
            exp_v = (qb.size() > 0) && (qb[0].due == eb);
            check("b_out_valid", bus_b.out_valid, exp_v);
            if (exp_v) begin
                e = qb.pop_front();
                if (bus_b.out_valid) begin
                    check("b_dout", bus_b.dout, e.d);
                    check("b_dout_sel", bus_b.dout_sel, e.s);
                end
            end
        end
    end

    // Advance n cycles; inputs change 1 time unit after each rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus_b.din      = 2'($urandom());
            bus_b.sel      = 1'($urandom());
            bus_b.scan_en  = 1'($urandom());
            bus_b.in_valid = ($urandom_range(3) != 0);
        end
    endtask

    task automatic rand_a();
        bus_a.din      = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus_a.sel      = 4'($urandom_range(15));
        bus_a.scan_en  = 1'($urandom());
        bus_a.in_valid = ($urandom_range(3) != 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_a_dout"}, bus_a.dout, 0);
        check({tag, "_a_dout_sel"}, bus_a.dout_sel, 0);
        check({tag, "_a_out_valid"}, bus_a.out_valid, 0);
        check({tag, "_a_scan_ptr"}, bus_a.scan_ptr, 0);
        check({tag, "_a_scan_wrap"}, bus_a.scan_wrap, 0);
        check({tag, "_b_dout"}, bus_b.dout, 0);
        check({tag, "_b_out_valid"}, bus_b.out_valid, 0);
        check({tag, "_b_scan_ptr"}, bus_b.scan_ptr, 0);
    endtask

    task automatic clear_models();
        qa.delete();
        qb.delete();
        sa = 0;
        sb = 0;
        exp_ptr_a = 0;
        exp_ptr_b = 0;
        exp_wrap_a = 1'b0;
        exp_wrap_b = 1'b0;
    endtask

    task automatic set_ramp_a();
        for (int i = 0; i < N_A; i++) bus_a.din[i*8 +: 8] = 8'h10 + 8'(i);
    endtask

    initial begin
        int sels [4];
        logic found;
        sels = '{0, 15, 7, 8};
        bus_a.din = '0; bus_a.sel = '0; bus_a.scan_en = 1'b0; bus_a.in_valid = 1'b0;
        bus_b.din = '0; bus_b.sel = '0; bus_b.scan_en = 1'b0; bus_b.in_valid = 1'b0;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("por");
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;

        // Single manual sample, sel=5
        set_ramp_a();
        bus_a.sel = 4'd5; bus_a.in_valid = 1'b1;
        step(1);
        bus_a.in_valid = 1'b0;
        step(8);

        // Back-to-back manual selects, then din changes under in-flight data
        for (int i = 0; i < 4; i++) begin
            bus_a.sel = 4'(sels[i]); bus_a.in_valid = 1'b1;
            step(1);
        end
        bus_a.in_valid = 1'b0;
        bus_a.din = {$urandom(), $urandom(), $urandom(), $urandom()};
        step(8);

        // Bubble pattern 1,0,1
        set_ramp_a();
        bus_a.sel = 4'd9;
        bus_a.in_valid = 1'b1; step(1);
        bus_a.in_valid = 1'b0; step(1);
        bus_a.in_valid = 1'b1; step(1);
        bus_a.in_valid = 1'b0; step(6);

        // Scan through a full wrap
        bus_a.scan_en = 1'b1; bus_a.in_valid = 1'b1;
        step(70);

        // Pause at pointer 6, dwell 2
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if ((sa % (N_A * DWELL_A)) == 26) found = 1'b1;
        end
        check("pause_reached", found, 1);
        bus_a.scan_en = 1'b0; bus_a.sel = 4'd3;
        step(10);
        check("pause_hold_ptr", bus_a.scan_ptr, 6);
        bus_a.scan_en = 1'b1;
        step(1);
        check("resume_ptr_1", bus_a.scan_ptr, 6);
        step(1);
        check("resume_ptr_2", bus_a.scan_ptr, 7);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_a();
            step(1);
        end

        // Asynchronous reset with data in flight
        bus_a.in_valid = 1'b1; bus_a.scan_en = 1'b0;
        step(3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero_outputs("async");
        clear_models();
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            rand_a();
            step(1);
        end

        // Drain
        bus_a.in_valid = 1'b0;
        step(10);
        check("a_queue_drained", qa.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
